// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and RUN/HALTED FSM.
// Optional performance counters are enabled with macro IF_FETCH_PERF_CNT_EN.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] HALT_INST0 = 32'h00c0_0093,
  parameter logic [31:0] HALT_INST1 = 32'h0000_8067
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        STALL_IF,
  input  logic        REDIRECT_EN,
  input  logic [31:0] REDIRECT_PC,
  input  logic [31:0] I_MEM_DI,
  output logic [31:0] I_MEM_ADDR,
  output logic        I_MEM_CSN,
  output logic [31:0] PC_IFID,
  output logic [31:0] ADD_PC_IFID,
  output logic [31:0] INST_IFID,
  output logic        VALID_IFID,
  output logic        HALT_IFID
`ifdef IF_FETCH_PERF_CNT_EN
  ,
  output logic [31:0] RUN_CNT,
  output logic [31:0] STALL_CNT
`endif
);

  typedef enum logic {RUN, HALTED} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] add_pc;
    logic [31:0] inst;
    logic        valid;
    logic        halt;
  } ifid_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] last_inst;
  logic        halt_hit;
  ifid_t       ifid;

  assign pc_plus4   = pc + 32'd4;
  assign halt_hit   = (last_inst == HALT_INST0) && (I_MEM_DI == HALT_INST1);

  assign I_MEM_ADDR  = pc;
  assign I_MEM_CSN   = (state == HALTED);
  assign PC_IFID     = ifid.pc;
  assign ADD_PC_IFID = ifid.add_pc;
  assign INST_IFID   = ifid.inst;
  assign VALID_IFID  = ifid.valid;
  assign HALT_IFID   = ifid.halt;

  // Priority: redirect > stall > halted bubble > normal fetch.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      pc        <= RESET_PC;
      state     <= RUN;
      last_inst <= '0;
      ifid      <= '0;
    end else if (REDIRECT_EN) begin
      pc        <= {REDIRECT_PC[31:2], 2'b00};
      state     <= RUN;
      last_inst <= '0;
      ifid      <= '0;
    end else if (STALL_IF) begin
      pc        <= pc;
    end else if (state == HALTED) begin
      ifid      <= '0;
    end else begin
      ifid.pc     <= pc;
      ifid.add_pc <= pc_plus4;
      ifid.inst   <= I_MEM_DI;
      ifid.valid  <= 1'b1;
      last_inst   <= I_MEM_DI;
      if (halt_hit) begin
        ifid.halt <= 1'b1;
        state     <= HALTED;
      end else begin
        ifid.halt <= 1'b0;
        pc        <= pc_plus4;
      end
    end
  end

`ifdef IF_FETCH_PERF_CNT_EN
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      RUN_CNT   <= '0;
      STALL_CNT <= '0;
    end else begin
      if (state == RUN && !STALL_IF && RUN_CNT != '1)
        RUN_CNT <= RUN_CNT + 32'd1;
      if (STALL_IF && !REDIRECT_EN && STALL_CNT != '1)
        STALL_CNT <= STALL_CNT + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: driver queues hand-computed post-edge state,
// monitor pops and compares one entry after each rising edge.
module tb_if_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] H0  = 32'h00c0_0093;
  localparam logic [31:0] H1  = 32'h0000_8067;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b1;
  logic        STALL_IF = 1'b0;
  logic        REDIRECT_EN = 1'b0;
  logic [31:0] REDIRECT_PC = '0;
  logic [31:0] I_MEM_DI = NOP;
  logic [31:0] I_MEM_ADDR;
  logic        I_MEM_CSN;
  logic [31:0] PC_IFID;
  logic [31:0] ADD_PC_IFID;
  logic [31:0] INST_IFID;
  logic        VALID_IFID;
  logic        HALT_IFID;
`ifdef IF_FETCH_PERF_CNT_EN
  logic [31:0] RUN_CNT;
  logic [31:0] STALL_CNT;
`endif

  if_fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .HALT_INST0(H0),
    .HALT_INST1(H1)
  ) dut (
    .CLK        (CLK),
    .RSTn       (RSTn),
    .STALL_IF   (STALL_IF),
    .REDIRECT_EN(REDIRECT_EN),
    .REDIRECT_PC(REDIRECT_PC),
    .I_MEM_DI   (I_MEM_DI),
    .I_MEM_ADDR (I_MEM_ADDR),
    .I_MEM_CSN  (I_MEM_CSN),
    .PC_IFID    (PC_IFID),
    .ADD_PC_IFID(ADD_PC_IFID),
    .INST_IFID  (INST_IFID),
    .VALID_IFID (VALID_IFID),
    .HALT_IFID  (HALT_IFID)
`ifdef IF_FETCH_PERF_CNT_EN
    ,
    .RUN_CNT    (RUN_CNT),
    .STALL_CNT  (STALL_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        csn;
    logic [31:0] pc_ifid;
    logic [31:0] add_pc;
    logic [31:0] inst;
    logic        valid;
    logic        halt;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic check_all(input exp_t e);
    check({e.tag, ".pc"},      I_MEM_ADDR,  e.pc);
    check({e.tag, ".csn"},     {31'd0, I_MEM_CSN},  {31'd0, e.csn});
    check({e.tag, ".pc_ifid"}, PC_IFID,     e.pc_ifid);
    check({e.tag, ".add_pc"},  ADD_PC_IFID, e.add_pc);
    check({e.tag, ".inst"},    INST_IFID,   e.inst);
    check({e.tag, ".valid"},   {31'd0, VALID_IFID}, {31'd0, e.valid});
    check({e.tag, ".halt"},    {31'd0, HALT_IFID},  {31'd0, e.halt});
  endtask

  // Drive one edge's inputs (caller is at a falling edge), queue the expected result, wait.
  task automatic step(input string tag, input logic stall, input logic redir,
                      input logic [31:0] rpc, input logic [31:0] di,
                      input logic [31:0] e_pc, input logic e_csn, input logic [31:0] e_pcifid,
                      input logic [31:0] e_inst, input logic e_valid, input logic e_halt);
    exp_t e;
    STALL_IF    = stall;
    REDIRECT_EN = redir;
    REDIRECT_PC = rpc;
    I_MEM_DI    = di;
    e.tag     = tag;
    e.pc      = e_pc;
    e.csn     = e_csn;
    e.pc_ifid = e_pcifid;
    e.add_pc  = e_valid ? e_pcifid + 32'd4 : 32'd0;
    e.inst    = e_inst;
    e.valid   = e_valid;
    e.halt    = e_halt;
    exp_q.push_back(e);
    @(negedge CLK);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 10) begin
      @(negedge CLK);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_reset(input string tag);
    exp_t e;
    e.tag = tag; e.pc = '0; e.csn = 1'b0; e.pc_ifid = '0; e.add_pc = '0;
    e.inst = '0; e.valid = 1'b0; e.halt = 1'b0;
    check_all(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_all(e);
      end
    end
  end

  initial begin : driver
    #1 RSTn = 1'b0;
    #1 check_reset("reset0");
    @(negedge CLK);
    @(negedge CLK);
    RSTn = 1'b1;
    //    tag       stl rd  rpc            di     pc            csn pc_ifid        inst   v  h
    step("f1",      0, 0, 32'h0,          NOP,   32'h04,        0, 32'h00,        NOP,   1, 0);
    step("f2",      0, 0, 32'h0,          NOP,   32'h08,        0, 32'h04,        NOP,   1, 0);
    step("f3",      0, 0, 32'h0,          NOP,   32'h0C,        0, 32'h08,        NOP,   1, 0);
    step("f4",      0, 0, 32'h0,          NOP,   32'h10,        0, 32'h0C,        NOP,   1, 0);
    step("stall1",  1, 0, 32'h0,          32'hAAAA_5555, 32'h10, 0, 32'h0C,       NOP,   1, 0);
    step("stall2",  1, 0, 32'h0,          32'hAAAA_5555, 32'h10, 0, 32'h0C,       NOP,   1, 0);
    step("resume",  0, 0, 32'h0,          NOP,   32'h14,        0, 32'h10,        NOP,   1, 0);
    step("redir",   1, 1, 32'h203,        NOP,   32'h200,       0, 32'h0,         32'h0, 0, 0);
    step("h0",      0, 0, 32'h0,          H0,    32'h204,       0, 32'h200,       H0,    1, 0);
    step("hstall",  1, 0, 32'h0,          H1,    32'h204,       0, 32'h200,       H0,    1, 0);
    step("h1",      0, 0, 32'h0,          H1,    32'h204,       1, 32'h204,       H1,    1, 1);
    step("hbub1",   0, 0, 32'h0,          NOP,   32'h204,       1, 32'h0,         32'h0, 0, 0);
    step("hbub2",   0, 0, 32'h0,          NOP,   32'h204,       1, 32'h0,         32'h0, 0, 0);
    step("hstl",    1, 0, 32'h0,          NOP,   32'h204,       1, 32'h0,         32'h0, 0, 0);
    step("hredir",  0, 1, 32'h40,         NOP,   32'h40,        0, 32'h0,         32'h0, 0, 0);
    step("run40",   0, 0, 32'h0,          NOP,   32'h44,        0, 32'h40,        NOP,   1, 0);
    step("sp_h0",   0, 0, 32'h0,          H0,    32'h48,        0, 32'h44,        H0,    1, 0);
    step("sp_rd",   0, 1, 32'h80,         H1,    32'h80,        0, 32'h0,         32'h0, 0, 0);
    step("sp_h1",   0, 0, 32'h0,          H1,    32'h84,        0, 32'h80,        H1,    1, 0);
    step("wr_rd",   0, 1, 32'hFFFF_FFFF,  NOP,   32'hFFFF_FFFC, 0, 32'h0,         32'h0, 0, 0);
    step("wrap",    0, 0, 32'h0,          NOP,   32'h0,         0, 32'hFFFF_FFFC, NOP,   1, 0);
    step("w_h0",    0, 0, 32'h0,          H0,    32'h04,        0, 32'h0,         H0,    1, 0);
    step("w_h1",    0, 0, 32'h0,          H1,    32'h04,        1, 32'h04,        H1,    1, 1);
    drain();
    #2 RSTn = 1'b0;
    #1 check_reset("async_rst");
    @(negedge CLK);
    @(negedge CLK);
    RSTn = 1'b1;
    step("r_f1",    0, 0, 32'h0,          NOP,   32'h04,        0, 32'h00,        NOP,   1, 0);
    step("r_f2",    0, 0, 32'h0,          H1,    32'h08,        0, 32'h04,        H1,    1, 0);
    drain();
`ifdef IF_FETCH_PERF_CNT_EN
    RSTn = 1'b0;
    #1 check("run_cnt_rst", RUN_CNT, 32'd0);
    check("stall_cnt_rst", STALL_CNT, 32'd0);
    @(negedge CLK);
    RSTn = 1'b1;
    STALL_IF = 1'b0; REDIRECT_EN = 1'b0; I_MEM_DI = NOP;
    repeat (5) @(negedge CLK);
    STALL_IF = 1'b1;
    repeat (3) @(negedge CLK);
    STALL_IF = 1'b0;
    check("run_cnt", RUN_CNT, 32'd5);
    check("stall_cnt", STALL_CNT, 32'd3);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/if_fetch_stage.md
IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have parameter HALT_INST0, default 32'h00c0_0093, first word of the halt pair.
REQ-003 SHALL have parameter HALT_INST1, default 32'h0000_8067, second word of the halt pair.
REQ-004 SHALL use one clock and an asynchronous active-low reset: ports CLK and RSTn.
REQ-005 SHALL have ports, in order:
 CLK  in  1  rising-edge clock.
 RSTn  in  1  async active-low reset.
 STALL_IF  in  1  hold PC and IF/ID register (hazard unit).
 REDIRECT_EN  in  1  taken branch/jump resolved downstream.
 REDIRECT_PC  in  32  redirect target.
 I_MEM_DI  in  32  instruction word read combinationally at I_MEM_ADDR.
 I_MEM_ADDR  out  32  current PC.
 I_MEM_CSN  out  1  instruction memory chip select, active low.
 PC_IFID  out  32  PC of the instruction in IF/ID.
 ADD_PC_IFID  out  32  PC_IFID + 4.
 INST_IFID  out  32  registered instruction.
 VALID_IFID  out  1  IF/ID holds a real instruction.
 HALT_IFID  out  1  IF/ID holds the second word of the halt pair.

Function
REQ-006 SHALL keep a two-state FSM: RUN, HALTED.
REQ-007 SHALL drive I_MEM_ADDR = PC combinationally; I_MEM_CSN = 0 in RUN, 1 in HALTED.
REQ-008 Per-edge priority SHALL be: REDIRECT_EN > STALL_IF > HALTED > normal fetch.
REQ-009 Normal fetch (RUN, no stall, no redirect) SHALL load IF/ID with PC, PC+4, I_MEM_DI, VALID=1 and set PC <= PC+4 (32-bit wrap, 32'hFFFF_FFFC -> 0).
REQ-010 REDIRECT_EN SHALL set PC <= {REDIRECT_PC[31:2],2'b00}, load IF/ID with all-zero bubble (VALID=0, HALT=0), clear halt-pair tracking, force FSM to RUN; STALL_IF in the same cycle is ignored.
REQ-011 STALL_IF without redirect SHALL hold PC, all IF/ID fields, FSM state and halt tracking unchanged.
REQ-012 SHALL keep LAST_INST = INST of the most recent valid IF/ID load; zeroed on redirect/reset.
REQ-013 When a normal fetch has LAST_INST == HALT_INST0 and I_MEM_DI == HALT_INST1, IF/ID SHALL load it with HALT_IFID=1, PC SHALL hold (not increment), FSM -> HALTED.
REQ-014 In HALTED without stall/redirect, IF/ID SHALL load all-zero bubble each edge and PC SHALL hold.
REQ-015 Redirect in HALTED SHALL resume RUN from target (speculative halt discarded).
REQ-016 Bubble values SHALL be zero for PC_IFID, ADD_PC_IFID, INST_IFID, VALID_IFID, HALT_IFID.
REQ-017 Halt pair split by stall cycles SHALL still be detected; split by redirect SHALL not.

Reset
REQ-018 RSTn low SHALL immediately (asynchronously) set PC=RESET_PC, FSM=RUN, LAST_INST=0, all IF/ID outputs 0.
REQ-019 Deassertion SHALL take effect on the next rising CLK; first fetch at RESET_PC; reset mid-stall or in HALTED SHALL behave identically.

Configuration
REQ-020 With macro IF_FETCH_PERF_CNT_EN defined, SHALL add outputs RUN_CNT[31:0] (edges in RUN without stall) and STALL_CNT[31:0] (edges with STALL_IF=1 and no redirect), saturating at 32'hFFFF_FFFF, reset to 0.
REQ-021 Without IF_FETCH_PERF_CNT_EN, those ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-022 Reset release, I_MEM_DI=32'h0000_0013 each cycle -> after 3 edges PC=0x0C, PC_IFID=0x08, ADD_PC_IFID=0x0C, VALID_IFID=1.
REQ-023 STALL_IF=1 for 2 edges at PC=0x10 -> PC, PC_IFID, INST_IFID unchanged both cycles; next edge resumes with PC_IFID=0x10.
REQ-024 REDIRECT_EN=1, REDIRECT_PC=0x203 with STALL_IF=1 -> next edge PC=0x200, VALID_IFID=0, INST_IFID=0.
REQ-025 Fetch 0x00c00093 then 0x00008067 -> HALT_IFID=1, I_MEM_CSN=1 next cycle, PC frozen, following IF/ID loads are bubbles.
REQ-026 In HALTED apply REDIRECT_PC=0x40 -> RUN, I_MEM_CSN=0, first valid PC_IFID=0x40; RSTn pulse low mid-cycle -> outputs zero before next edge.
REQ-027 With IF_FETCH_PERF_CNT_EN: 5 run edges, 3 stall edges -> RUN_CNT=5, STALL_CNT=3.
